// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor using one full-adder cell over WIDTH cycles.
// Subtraction is a + ~b + 1, with the +1 supplied as the initial carry.
module serial_add_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             finalcarry,
    output logic             overflow,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_ps;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic             w_s, w_co, w_last;

    assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
    assign w_co   = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
    assign w_last = r_cnt == CW'(WIDTH - 1);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state == IDLE ? (start ? RUN : IDLE) :
                 r_state == RUN  ? (w_last ? DONE : RUN) : IDLE;
        busy   = r_state != IDLE;
        done   = r_state == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_ps       <= '0;
            r_c        <= 1'b0;
            r_cnt      <= '0;
            sum        <= '0;
            finalcarry <= 1'b0;
            overflow   <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_a   <= a;
            r_b   <= mode ? ~b : b;
            r_c   <= mode;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_c   <= w_co;
            r_ps  <= {w_s, r_ps[WIDTH-1:1]};
            r_cnt <= r_cnt + CW'(1);
            // r_c here is the carry into the MSB, so overflow is carry-in ^ carry-out
            if (w_last) begin
                sum        <= {w_s, r_ps[WIDTH-1:1]};
                finalcarry <= w_co;
                overflow   <= r_c ^ w_co;
            end
        end
    end
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed and randomized checks of serial_add_sub at WIDTH=4 and WIDTH=8.
module tb_serial_add_sub;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start4 = 1'b0, start8 = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic [3:0] sum4;
    logic [7:0] sum8;
    logic       fc4, ov4, busy4, done4, fc8, ov8, busy8, done8;
    int         n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode), .a(a[3:0]), .b(b[3:0]),
        .sum(sum4), .finalcarry(fc4), .overflow(ov4), .busy(busy4), .done(done4)
    );

    serial_add_sub #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode), .a(a), .b(b),
        .sum(sum8), .finalcarry(fc8), .overflow(ov8), .busy(busy8), .done(done8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Returns {overflow, finalcarry, sum zero-extended to 8 bits}
    function automatic logic [9:0] model(input int w, input logic m, input logic [7:0] x, input logic [7:0] y);
        int mask, xa, ya, t, s;
        logic fc, ov, sa, sy, ss;
        mask = (1 << w) - 1;
        xa   = int'(x) & mask;
        ya   = m ? ((~int'(y) & mask) + 1) : (int'(y) & mask);
        t    = xa + ya;
        s    = t & mask;
        fc   = ((t >> w) & 1) != 0;
        sa   = x[w-1];
        sy   = y[w-1];
        ss   = ((s >> (w - 1)) & 1) != 0;
        ov   = m ? (sa != sy && ss != sa) : (sa == sy && ss != sa);
        return {ov, fc, 8'(s)};
    endfunction

    function automatic logic [9:0] res4();
        return {ov4, fc4, 4'b0, sum4};
    endfunction

    task automatic run_op(input int w, input logic m, input logic [7:0] x, input logic [7:0] y,
                          output logic [9:0] res);
        int   k;
        logic seen;
        @(negedge clk);
        mode = m; a = x; b = y;
        if (w == 4) start4 = 1'b1; else start8 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; start8 = 1'b0;
        k = 0; seen = 1'b0;
        while (!seen && k < w + 4) begin
            @(negedge clk);
            k++;
            seen = (w == 4) ? done4 : done8;
        end
        check("latency", k, w);
        res = (w == 4) ? res4() : {ov8, fc8, sum8};
        @(negedge clk);
        check("idle_after_done", (w == 4) ? {busy4, done4} : {busy8, done8}, 0);
    endtask

    initial begin
        logic [9:0] r, r_first;
        int         cyc, done_cyc, n_done;
        start4 = 1'b1; start8 = 1'b1;
        a = 8'($urandom); b = 8'($urandom); mode = 1'b1;
        repeat (2) @(negedge clk);
        check("reset4", {res4(), busy4, done4}, 0);
        check("reset8", {ov8, fc8, sum8, busy8, done8}, 0);
        rst = 1'b0; start4 = 1'b0; start8 = 1'b0;

        run_op(4, 1'b0, 8'hB, 8'h6, r); check("add4_b_6", r, 10'b01_0000_0001);
        run_op(4, 1'b0, 8'h7, 8'h1, r); check("add4_7_1", r, 10'b10_0000_1000);
        run_op(4, 1'b1, 8'h5, 8'h7, r); check("sub4_5_7", r, 10'b00_0000_1110);
        run_op(4, 1'b1, 8'h8, 8'h1, r); check("sub4_8_1", r, 10'b11_0000_0111);
        run_op(8, 1'b0, 8'hC8, 8'h64, r); check("add8_c8_64", r, 10'b01_0010_1100);

        // start pulsed mid-run must be ignored
        @(negedge clk);
        mode = 1'b0; a = 8'h3; b = 8'h2; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; cyc = 0;
        repeat (2) begin @(negedge clk); cyc++; end
        mode = 1'b1; a = 8'h1; b = 8'h4; start4 = 1'b1;
        @(negedge clk); cyc++;
        start4 = 1'b0;
        n_done = 0; done_cyc = -1; r_first = '0;
        repeat (10) begin
            @(negedge clk); cyc++;
            if (done4) begin
                if (n_done == 0) begin done_cyc = cyc; r_first = res4(); end
                n_done++;
            end
        end
        check("hs_done_cycle", done_cyc, 4);
        check("hs_done_count", n_done, 1);
        check("hs_result", r_first, 10'b00_0000_0101);

        // reset in the middle of RUN aborts without a done pulse
        @(negedge clk);
        mode = 1'b0; a = 8'hB; b = 8'h6; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outputs", {res4(), busy4, done4}, 0);
        n_done = 0;
        repeat (8) begin @(negedge clk); if (done4) n_done++; end
        check("abort_no_done", n_done, 0);
        run_op(4, 1'b1, 8'h2, 8'h9, r); check("after_abort", r, model(4, 1'b1, 8'h2, 8'h9));

        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++) begin
                    run_op(4, m[0], 8'(x), 8'(y), r);
                    check("exh4", r, model(4, m[0], 8'(x), 8'(y)));
                end

        for (int i = 0; i < 1000; i++) begin
            logic       m;
            logic [7:0] x, y;
            m = 1'($urandom);
            x = 8'($urandom);
            y = 8'($urandom);
            run_op(8, m, x, y, r);
            check("rand8", r, model(8, m, x, y));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
